// File: rtl/rob_controller_pkg.sv
// ----------------------------------------------------------------------------
// rob_controller_pkg
// Shared constants for the reorder-buffer controller and the stages that
// exchange ROB tags with it (allocator, issue, retire).
//   ROB_SIZE_DEFAULT : default number of ROB entries (power of two, >= 4)
//   TAG_W_DEFAULT    : tag width for the default size (index width + 1)
//   rob_tag_t        : tag type for the default configuration
//   TAG_INVALID      : tag value 0, never granted, always ignored on input
// ----------------------------------------------------------------------------
package rob_controller_pkg;

    localparam int ROB_SIZE_DEFAULT = 16;
    localparam int TAG_W_DEFAULT    = $clog2(ROB_SIZE_DEFAULT) + 1;

    typedef logic [TAG_W_DEFAULT-1:0] rob_tag_t;

    localparam rob_tag_t TAG_INVALID = {TAG_W_DEFAULT{1'b0}};

endpackage

// File: rtl/rob_squash_mask.sv
// ----------------------------------------------------------------------------
// rob_squash_mask
// Combinational circular range mask: bit i is set when entry index i lies in
// [start_idx, end_idx) walking upward modulo ROB_SIZE. start_idx == end_idx
// yields an empty mask.
//   start_idx : first index to mark (oldest squashed entry)
//   end_idx   : one past the last index to mark (current tail)
//   mask      : one bit per ROB entry
// ----------------------------------------------------------------------------
module rob_squash_mask #(
    parameter int ROB_SIZE = 16
) (
    input  logic [$clog2(ROB_SIZE)-1:0] start_idx,
    input  logic [$clog2(ROB_SIZE)-1:0] end_idx,
    output logic [ROB_SIZE-1:0]         mask
);

    localparam int IDX_W = $clog2(ROB_SIZE);

    logic [IDX_W-1:0] len_s;
    logic [IDX_W-1:0] off_s;

    // Mark every index whose circular distance from start is below the range length.
    always_comb begin
        len_s = end_idx - start_idx;
        off_s = {IDX_W{1'b0}};
        mask  = {ROB_SIZE{1'b0}};
        for (int i = 0; i < ROB_SIZE; i++) begin
            off_s   = IDX_W'(i) - start_idx;
            mask[i] = (off_s < len_s);
        end
    end

endmodule

// File: rtl/rob_controller.sv
// ----------------------------------------------------------------------------
// rob_controller
// Reorder-buffer bookkeeping: in-order allocation of tags, out-of-order
// completion marking, in-order retirement and branch-mispredict squash.
// Tags are entry index + 1, so tag 0 never names an entry.
//   clk, reset      : clock, asynchronous active-low reset
//   alloc_req       : dispatch wants one entry      -> alloc_ready, alloc_tag
//   complete_valid  : an instruction finished       <- complete_tag
//   commit_valid    : head entry done, may retire   -> commit_tag
//   commit_ack      : retire stage consumed the head
//   flush/flush_tag : squash every entry younger than flush_tag
//   count/full/empty: occupancy status
// ----------------------------------------------------------------------------
module rob_controller
    import rob_controller_pkg::*;
#(
    parameter int ROB_SIZE = ROB_SIZE_DEFAULT,
    parameter int TAG_W    = $clog2(ROB_SIZE) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             complete_valid,
    input  logic [TAG_W-1:0] complete_tag,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    input  logic             commit_ack,
    input  logic             flush,
    input  logic [TAG_W-1:0] flush_tag,
    output logic [TAG_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int               IDX_W    = $clog2(ROB_SIZE);
    localparam logic [TAG_W-1:0] SIZE_TAG = TAG_W'(ROB_SIZE);
    localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_INVALID);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

    // A tag names an entry only when it is in 1..ROB_SIZE.
    function automatic logic tag_valid(input logic [TAG_W-1:0] t);
        return (t != TAG_NONE) && (t <= SIZE_TAG);
    endfunction

    function automatic logic [IDX_W-1:0] tag2idx(input logic [TAG_W-1:0] t);
        logic [TAG_W-1:0] m;
        m = t - TAG_ONE;
        return m[IDX_W-1:0];
    endfunction

    logic [IDX_W-1:0]    head_q, head_d;
    logic [IDX_W-1:0]    tail_q, tail_d;
    logic [TAG_W-1:0]    count_q, count_d;
    logic [ROB_SIZE-1:0] busy_q, busy_d;
    logic [ROB_SIZE-1:0] done_q, done_d;

    logic [IDX_W-1:0]    comp_idx_s;
    logic [IDX_W-1:0]    flush_idx_s;
    logic [IDX_W-1:0]    keep_dist_s;
    logic [TAG_W-1:0]    survivors_s;
    logic [ROB_SIZE-1:0] squash_mask_s;
    logic                comp_hit_s;
    logic                flush_ok_s;
    logic                grant_s;
    logic                retire_s;

    // Status and handshake outputs come straight from registered state.
    assign full         = (count_q == SIZE_TAG);
    assign empty        = (count_q == TAG_NONE);
    assign count        = count_q;
    assign alloc_ready  = !full;
    assign alloc_tag    = TAG_W'(tail_q) + TAG_ONE;
    assign commit_valid = !empty && done_q[head_q];
    assign commit_tag   = TAG_W'(head_q) + TAG_ONE;

    // Squashed entries run from just after the surviving tag up to tail-1.
    rob_squash_mask #(
        .ROB_SIZE (ROB_SIZE)
    ) u_squash_mask (
        .start_idx (flush_idx_s + IDX_W'(1)),
        .end_idx   (tail_q),
        .mask      (squash_mask_s)
    );

    // Decode the events that act on state this cycle.
    always_comb begin
        comp_idx_s  = tag2idx(complete_tag);
        flush_idx_s = tag2idx(flush_tag);
        comp_hit_s  = complete_valid && tag_valid(complete_tag) && busy_q[comp_idx_s];
        flush_ok_s  = flush && tag_valid(flush_tag) && busy_q[flush_idx_s];
        grant_s     = alloc_req && alloc_ready && !flush;
        retire_s    = commit_valid && commit_ack;
        // Entries head..flush_idx survive; a zero distance means exactly one.
        keep_dist_s = flush_idx_s - head_q;
        survivors_s = TAG_W'(keep_dist_s) + TAG_ONE;
    end

    // Next-state: completion, then retire, then squash or grant.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q;

        if (comp_hit_s) begin
            done_d[comp_idx_s] = 1'b1;
        end else begin
            done_d = done_d;
        end

        // Retire clears after completion, so a same-cycle completion of the head is moot.
        if (retire_s) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + IDX_W'(1);
        end else begin
            head_d = head_q;
        end

        if (flush_ok_s) begin
            busy_d  = busy_d & ~squash_mask_s;
            done_d  = done_d & ~squash_mask_s;
            tail_d  = flush_idx_s + IDX_W'(1);
            count_d = survivors_s - TAG_W'(retire_s);
        end else if (grant_s) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = tail_q + IDX_W'(1);
            count_d        = retire_s ? count_q : (count_q + TAG_ONE);
        end else begin
            tail_d  = tail_q;
            count_d = retire_s ? (count_q - TAG_ONE) : count_q;
        end
    end

    // State registers; reset discards every entry at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= {IDX_W{1'b0}};
            tail_q  <= {IDX_W{1'b0}};
            count_q <= {TAG_W{1'b0}};
            busy_q  <= {ROB_SIZE{1'b0}};
            done_q  <= {ROB_SIZE{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_rob_controller.sv
// ----------------------------------------------------------------------------
// tb_rob_controller
// Directed bench for a 4-entry ROB. Expected grant and retire tags are queued
// by the stimulus; a negedge monitor pops and compares whenever a handshake
// fires. Occupancy and status outputs are compared directly after each step.
// ----------------------------------------------------------------------------
module tb_rob_controller;

    localparam int RS = 4;
    localparam int TW = 3;

    logic          clk;
    logic          reset;
    logic          alloc_req;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic          complete_valid;
    logic [TW-1:0] complete_tag;
    logic          commit_valid;
    logic [TW-1:0] commit_tag;
    logic          commit_ack;
    logic          flush;
    logic [TW-1:0] flush_tag;
    logic [TW-1:0] count;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_alloc[$];
    int exp_commit[$];

    rob_controller #(
        .ROB_SIZE (RS),
        .TAG_W    (TW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .complete_valid (complete_valid),
        .complete_tag   (complete_tag),
        .commit_valid   (commit_valid),
        .commit_tag     (commit_tag),
        .commit_ack     (commit_ack),
        .flush          (flush),
        .flush_tag      (flush_tag),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req      = 1'b0;
        complete_valid = 1'b0;
        complete_tag   = 3'd0;
        commit_ack     = 1'b0;
        flush          = 1'b0;
        flush_tag      = 3'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic complete(input logic [TW-1:0] t);
        complete_valid = 1'b1;
        complete_tag   = t;
        tick();
        complete_valid = 1'b0;
        complete_tag   = 3'd0;
    endtask

    // Scoreboard monitor: every handshake consumes one queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (alloc_req && alloc_ready && !flush) begin
                if (exp_alloc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL alloc_unexpected: got tag %0d, expected no grant", alloc_tag);
                end else begin
                    check("alloc_tag", 32'(alloc_tag), 32'(exp_alloc.pop_front()));
                end
            end
            if (commit_valid && commit_ack) begin
                if (exp_commit.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL commit_unexpected: got tag %0d, expected no retire", commit_tag);
                end else begin
                    check("commit_tag", 32'(commit_tag), 32'(exp_commit.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        #12;
        // Reset values
        check("rst_alloc_ready",  32'(alloc_ready),  32'd1);
        check("rst_alloc_tag",    32'(alloc_tag),    32'd1);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_commit_tag",   32'(commit_tag),   32'd1);
        check("rst_empty",        32'(empty),        32'd1);
        check("rst_full",         32'(full),         32'd0);
        check("rst_count",        32'(count),        32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // commit_ack while empty is ignored
        commit_ack = 1'b1;
        tick();
        commit_ack = 1'b0;
        check("ack_empty_count", 32'(count),      32'd0);
        check("ack_empty_ctag",  32'(commit_tag), 32'd1);

        // Fill: tags 1..4, then one refused request while full
        for (int i = 1; i <= 4; i++) exp_alloc.push_back(i);
        alloc_req = 1'b1;
        repeat (4) tick();
        check("fill_full",  32'(full),        32'd1);
        check("fill_ready", 32'(alloc_ready), 32'd0);
        check("fill_count", 32'(count),       32'd4);
        tick();
        alloc_req = 1'b0;
        check("full_hold_count", 32'(count), 32'd4);

        // Out-of-order completion; head waits for tag 1
        complete(3'd2);
        check("ooo_cv_wait", 32'(commit_valid), 32'd0);
        complete(3'd1);
        check("ooo_cv", 32'(commit_valid), 32'd1);
        check("ooo_ct", 32'(commit_tag),   32'd1);
        exp_commit.push_back(1);
        exp_commit.push_back(2);
        commit_ack = 1'b1;
        tick();
        check("ret1_count", 32'(count),        32'd3);
        check("ret1_cv",    32'(commit_valid), 32'd1);
        check("ret1_ct",    32'(commit_tag),   32'd2);
        tick();
        commit_ack = 1'b0;
        check("ret2_count", 32'(count),        32'd2);
        check("ret2_cv",    32'(commit_valid), 32'd0);
        check("ret2_ct",    32'(commit_tag),   32'd3);

        // Ignored events: tag 0, not-busy completion, not-busy and zero flush
        complete(3'd0);
        complete(3'd1);
        flush = 1'b1;
        flush_tag = 3'd1;
        tick();
        flush_tag = 3'd0;
        tick();
        flush = 1'b0;
        check("ign_count",  32'(count),        32'd2);
        check("ign_cv",     32'(commit_valid), 32'd0);
        check("ign_atag",   32'(alloc_tag),    32'd1);
        complete(3'd3);
        exp_commit.push_back(3);
        commit_ack = 1'b1;
        tick();
        commit_ack = 1'b0;
        check("ign_tag0_cv", 32'(commit_valid), 32'd0);
        check("ign_ct4",     32'(commit_tag),   32'd4);
        check("ign_count1",  32'(count),        32'd1);

        // Full ROB: retire and request together -> no grant, then wrap grant
        do_reset();
        for (int i = 1; i <= 4; i++) exp_alloc.push_back(i);
        alloc_req = 1'b1;
        repeat (4) tick();
        alloc_req = 1'b0;
        complete(3'd1);
        exp_commit.push_back(1);
        commit_ack = 1'b1;
        alloc_req  = 1'b1;
        tick();
        commit_ack = 1'b0;
        check("wrap_count3", 32'(count),       32'd3);
        check("wrap_ready",  32'(alloc_ready), 32'd1);
        check("wrap_atag",   32'(alloc_tag),   32'd1);
        exp_alloc.push_back(1);
        tick();
        alloc_req = 1'b0;
        check("wrap_count4", 32'(count), 32'd4);
        check("wrap_full",   32'(full),  32'd1);

        // Flush with tag 2 while full, with a competing request
        do_reset();
        for (int i = 1; i <= 4; i++) exp_alloc.push_back(i);
        alloc_req = 1'b1;
        repeat (4) tick();
        flush     = 1'b1;
        flush_tag = 3'd2;
        tick();
        flush     = 1'b0;
        alloc_req = 1'b0;
        check("fl_count", 32'(count),     32'd2);
        check("fl_atag",  32'(alloc_tag), 32'd3);
        complete(3'd4);
        check("fl_c4_count", 32'(count),        32'd2);
        check("fl_c4_cv",    32'(commit_valid), 32'd0);
        exp_alloc.push_back(3);
        alloc_req = 1'b1;
        tick();
        check("fl_realloc_count", 32'(count), 32'd3);
        // Flush while not full still blocks the grant
        flush     = 1'b1;
        flush_tag = 3'd1;
        tick();
        flush     = 1'b0;
        alloc_req = 1'b0;
        check("fl2_count", 32'(count),     32'd1);
        check("fl2_atag",  32'(alloc_tag), 32'd2);

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 1; i <= 3; i++) exp_alloc.push_back(i);
        alloc_req = 1'b1;
        repeat (3) tick();
        alloc_req = 1'b0;
        complete(3'd1);
        check("pre_ar_count", 32'(count),        32'd3);
        check("pre_ar_cv",    32'(commit_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_count", 32'(count),        32'd0);
        check("ar_cv",    32'(commit_valid), 32'd0);
        check("ar_empty", 32'(empty),        32'd1);
        check("ar_atag",  32'(alloc_tag),    32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        exp_alloc.push_back(1);
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        check("post_ar_count", 32'(count), 32'd1);

        // Grant and retire in the same cycle keep count
        complete(3'd1);
        exp_commit.push_back(1);
        exp_alloc.push_back(2);
        commit_ack = 1'b1;
        alloc_req  = 1'b1;
        tick();
        commit_ack = 1'b0;
        alloc_req  = 1'b0;
        check("gr_count", 32'(count),      32'd1);
        check("gr_ct",    32'(commit_tag), 32'd2);

        tick();
        check("alloc_queue_drained",  32'(exp_alloc.size()),  32'd0);
        check("commit_queue_drained", 32'(exp_commit.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_controller.md
ROB_CONTROLLER -- requirements
Module: rob_controller

Interface
REQ-001 Parameter ROB_SIZE, default 16, number of reorder-buffer entries; power of two, >= 4.
REQ-002 Parameter TAG_W, default $clog2(ROB_SIZE)+1, width of tag and count fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 alloc_req  input  1  dispatch requests one ROB entry this cycle.
REQ-006 alloc_ready  output  1  an entry can be granted this cycle.
REQ-007 alloc_tag  output  TAG_W  tag granted when alloc_req && alloc_ready; tag = tail index + 1, never 0.
REQ-008 complete_valid  input  1  execute/CDB reports that an instruction finished.
REQ-009 complete_tag  input  TAG_W  tag of the finished instruction.
REQ-010 commit_valid  output  1  the head entry is done and may retire.
REQ-011 commit_tag  output  TAG_W  tag of the head entry.
REQ-012 commit_ack  input  1  the retire stage consumed commit_tag this cycle.
REQ-013 flush  input  1  branch mispredict recovery request.
REQ-014 flush_tag  input  TAG_W  last surviving tag; every entry younger than it is squashed.
REQ-015 count  output  TAG_W  number of occupied entries, range 0..ROB_SIZE.
REQ-016 full, empty  output  1 each  count == ROB_SIZE, count == 0.

Function
REQ-017 State: head index, tail index, count register, per-entry busy and done bits.
REQ-018 alloc_ready = !full, taken from registered state only; a same-cycle commit does not free a slot for that cycle's allocation.
REQ-019 A grant (alloc_req && alloc_ready && !flush) sets busy, clears done at tail, and advances tail modulo ROB_SIZE; alloc_tag is combinational from tail.
REQ-020 A completion sets done when the entry for complete_tag is busy; otherwise it is ignored. Tag 0 is always ignored.
REQ-021 commit_valid = !empty && done[head]; commit_tag = head + 1; both are combinational from state.
REQ-022 A retire (commit_valid && commit_ack) clears busy and done at head and advances head modulo ROB_SIZE; commit_ack without commit_valid is ignored.
REQ-023 Grant and retire in the same cycle leave count unchanged; grant alone adds 1; retire alone subtracts 1.
REQ-024 A completion in the same cycle as a retire of the same head entry has no further effect.
REQ-025 Flush clears busy and done on entries from flush_tag+1 up to tail-1 in circular order, and sets tail to flush_tag (index flush_tag-1, plus 1, wrapped).
REQ-026 After a flush, count = (tail_new - head) mod ROB_SIZE, plus ROB_SIZE if entries remain and tail_new == head; the retire in the same cycle is applied first.
REQ-027 Flush has priority over allocation: no grant happens in a flush cycle. Retire and completion of surviving entries in that cycle still take effect.
REQ-028 A flush with flush_tag not busy, or equal to 0, is ignored.
REQ-029 Pointer wrap is always modulo ROB_SIZE; an equal head and tail are disambiguated by count.

Reset
REQ-030 While reset is low: head = 0, tail = 0, count = 0, all busy and done bits = 0.
REQ-031 Resulting outputs during reset: alloc_ready = 1, alloc_tag = 1, commit_valid = 0, commit_tag = 1, empty = 1, full = 0.
REQ-032 Reset asserted mid-operation discards all entries immediately; the first grant after release is tag 1.

Structure
REQ-033 ROB_SIZE default, the tag typedef and the "tag 0 = invalid" constant belong in the shared consts package used by the allocator and issue stages.
REQ-034 The design is a single module; an optional sub-module rob_squash_mask (combinational circular range mask from flush_tag to tail) is permitted.

Verification
REQ-035 ROB_SIZE=4, after reset, alloc_req for 4 cycles -> tags 1,2,3,4; full=1, alloc_ready=0, count=4.
REQ-036 Complete tag 2 then tag 1 -> commit_valid is 0 until tag 1 is done; with commit_ack held, commit_tag is 1 then 2 on consecutive cycles; count goes 4 -> 2.
REQ-037 Full ROB, with commit_ack and alloc_req in the same cycle -> retire happens, no grant; next cycle alloc_tag=1 (wrap) is granted; count stays 3 then returns to 4.
REQ-038 Tags 1..4 allocated, flush with flush_tag=2 plus alloc_req -> no grant, count=2, next alloc_tag=3, and a later complete_tag=4 is ignored.
REQ-039 Reset asserted asynchronously while count=3 and commit_valid=1 -> outputs reach reset values before the next clock edge; first grant after release is tag 1.
REQ-040 Boundary checks: complete_tag=0, completion of a not-busy tag, and commit_ack when empty -> no state change, confirmed by assertions.
